// File: rtl/tfe_latency_profiler_pkg.sv
// tfe_prof_pkg: shared definitions for the TFE latency profiler.
//   TIME_W     - timer timestamp width (wraps mod 2^TIME_W)
//   DROP_W     - width of the saturating dropped-record counter
//   TAG_W_DEF  - default task tag width
//   state_t    - measurement FSM state
//   prof_rec_t - {tag, elapsed} record at the default tag width
package tfe_prof_pkg;

  localparam int TIME_W    = 34;
  localparam int DROP_W    = 16;
  localparam int TAG_W_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [TIME_W-1:0]    elapsed;
  } prof_rec_t;

endpackage

// File: rtl/tfe_latency_profiler_if.sv
// Record drain handshake between the profiler and the host/debug consumer.
//   rec_valid   - head record available (profiler -> consumer)
//   rec_ready   - consumer accepts head record (consumer -> profiler)
//   rec_tag     - head record tag
//   rec_elapsed - head record elapsed cycles
// master: record source (profiler); slave: record sink (consumer).
interface tfe_latency_profiler_if
  import tfe_prof_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) ();

  logic              rec_valid;
  logic              rec_ready;
  logic [TAG_W-1:0]  rec_tag;
  logic [TIME_W-1:0] rec_elapsed;

  modport master (
    output rec_valid,
    input  rec_ready,
    output rec_tag,
    output rec_elapsed
  );

  modport slave (
    input  rec_valid,
    output rec_ready,
    input  rec_tag,
    input  rec_elapsed
  );

endinterface

// File: rtl/tfe_latency_profiler_fifo.sv
// tfe_prof_fifo: synchronous show-ahead FIFO, DEPTH entries (power of two).
//   clk, rst  - clock, synchronous active-high reset (flushes contents)
//   push/data - write request; ignored when full unless a pop frees a slot
//   pop       - read request; ignored when empty
//   head      - current head entry (zero while empty)
//   valid     - not empty
//   full      - DEPTH entries held
module tfe_prof_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & valid;
  // A pop in the same cycle frees a slot, so a push on full is still taken.
  assign do_push = push & (~full | do_pop);
  // Head is gated so the record outputs read zero after reset/drain.
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tfe_latency_profiler.sv
// tfe_latency_profiler: measures cycles between task start and done strobes
// using the free-running timer timestamp, queuing {tag, elapsed} records.
//   clk, rst        - clock (same as timer), synchronous active-high reset
//   i_time          - current timestamp, sampled with the strobes
//   i_start, i_tag  - task start strobe and its tag
//   i_done          - task done strobe
//   rec             - record drain handshake (master side)
//   o_busy          - measurement in progress
//   o_overlap_err   - sticky: start seen while a measurement was running
//   o_drop_cnt      - saturating count of records lost to a full FIFO
//   o_max_elapsed   - largest elapsed seen; built only with TFE_PROF_MAX_EN,
//                     otherwise tied to zero
//
// state   | meaning
// ST_IDLE | no measurement open; start opens one, start+done logs zero
// ST_RUN  | measurement open; done closes it (start+done restarts)
module tfe_latency_profiler
  import tfe_prof_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] i_time,
  input  logic              i_start,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_done,
  tfe_latency_profiler_if.master rec,
  output logic              o_busy,
  output logic              o_overlap_err,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic [TIME_W-1:0] o_max_elapsed
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [TIME_W-1:0] elapsed;
  } rec_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] t_start_q;
  logic [TAG_W-1:0]  tag_q;
  logic              push, latch, overlap_set;
  logic              pop, drop, fifo_valid, fifo_full;
  rec_t              push_rec, head_rec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      t_start_q     <= '0;
      tag_q         <= '0;
      o_overlap_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        t_start_q <= i_time;
        tag_q     <= i_tag;
      end
      if (overlap_set) o_overlap_err <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    push             = 1'b0;
    latch            = 1'b0;
    overlap_set      = 1'b0;
    push_rec.tag     = tag_q;
    // Unsigned subtract modulo 2^TIME_W handles a single timer wrap.
    push_rec.elapsed = i_time - t_start_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_done) begin
            push             = 1'b1;
            push_rec.tag     = i_tag;
            push_rec.elapsed = '0;
          end else begin
            latch   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (i_done) begin
          push = 1'b1;
          if (i_start) latch = 1'b1;
          else         state_d = ST_IDLE;
        end else if (i_start) begin
          overlap_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy = (state_q == ST_RUN);

  tfe_prof_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rec_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .data  (push_rec),
    .pop   (pop),
    .head  (head_rec),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign pop             = fifo_valid & rec.rec_ready;
  assign drop            = push & fifo_full & ~pop;
  assign rec.rec_valid   = fifo_valid;
  assign rec.rec_tag     = head_rec.tag;
  assign rec.rec_elapsed = head_rec.elapsed;

  always_ff @(posedge clk) begin
    if (rst)                                 o_drop_cnt <= '0;
    else if (drop && (o_drop_cnt != '1))     o_drop_cnt <= o_drop_cnt + DROP_W'(1);
  end

`ifdef TFE_PROF_MAX_EN
  logic [TIME_W-1:0] max_q;

  // Dropped records still count toward the maximum.
  always_ff @(posedge clk) begin
    if (rst)                                    max_q <= '0;
    else if (push && (push_rec.elapsed > max_q)) max_q <= push_rec.elapsed;
  end

  assign o_max_elapsed = max_q;
`else
  assign o_max_elapsed = '0;
`endif

endmodule

// File: doc/tfe_latency_profiler.md
# tfe_latency_profiler

Consumes the free-running 34-bit timestamp from the TFE timer and measures elapsed cycles between an inference task's start and done strobes. Each completed measurement is pushed as a {tag, elapsed} record into a small FIFO that the host/debug side drains over a valid/ready handshake. It sits directly downstream of the timer, beside the inference engine control path.

## Interface
- DEPTH, 8, record FIFO depth (power of two, ≥2)
- TAG_W, 4, task tag width
- clk  in  1  clock; same clock as the timer
- rst  in  1  reset, synchronous, active-high
- i_time  in  34  current timestamp from the timer (registered, wraps mod 2^34)
- i_start  in  1  task start strobe (1 cycle)
- i_tag  in  TAG_W  task tag, sampled with i_start
- i_done  in  1  task done strobe (1 cycle)
- o_rec_valid  out  1  FIFO head record available
- i_rec_ready  in  1  consumer accepts head record
- o_rec_tag  out  TAG_W  head record tag
- o_rec_elapsed  out  34  head record elapsed cycles
- o_busy  out  1  measurement in progress
- o_overlap_err  out  1  sticky: i_start seen while busy
- o_drop_cnt  out  16  saturating count of records dropped on full FIFO
- o_max_elapsed  out  34  largest elapsed value recorded (only with TFE_PROF_MAX_EN)

## Operation
- FSM states IDLE, RUN.
- IDLE, i_start=1 & i_done=0: latch t_start=i_time, tag=i_tag; -> RUN.
- IDLE, i_done=0/1 without i_start: ignored.
- IDLE, i_start=1 & i_done=1: record {i_tag, 0} pushed; stay IDLE.
- RUN, i_done=1: elapsed=(i_time − t_start) mod 2^34 (34-bit unsigned subtract, carry discarded); push {tag, elapsed}. If i_start also 1: relatch t_start=i_time, tag=i_tag, stay RUN (back-to-back); else -> IDLE.
- RUN, i_start=1 & i_done=0: start ignored, o_overlap_err set; original measurement continues.
- Wrap-around: single timer wrap between start and done gives correct result; measurements ≥2^34 cycles alias (not detected).
- Push while FIFO full: record discarded, o_drop_cnt += 1, saturating at 16'hFFFF. Push and pop in same cycle when full: pop frees a slot, push accepted.
- Pop when o_rec_valid & i_rec_ready. Head outputs stable while valid & !ready.
- o_overlap_err clears only on rst.

## Timing
- Reset values: FSM IDLE, o_busy=0, o_rec_valid=0, o_rec_tag=0, o_rec_elapsed=0, o_overlap_err=0, o_drop_cnt=0, o_max_elapsed=0, FIFO empty.
- i_time sampled in the same cycle as the strobe.
- o_busy rises the cycle after accepted i_start, falls the cycle after i_done.
- Record visible on o_rec_valid/o_rec_* one cycle after i_done (FIFO empty case); no combinational path from i_done to outputs.
- i_rec_ready → next record visible next cycle; full throughput 1 record/cycle.
- rst mid-RUN: measurement abandoned, no record pushed, FIFO contents flushed.

## Configuration
- TFE_PROF_MAX_EN defined: o_max_elapsed register updates on every accepted or dropped push when elapsed > current value; one cycle after i_done.
- Undefined: o_max_elapsed port present, tied to 0; comparator and register not built.

## Structure
- Package tfe_prof_pkg: TIME_W=34, DROP_W=16, FSM state enum, record struct {tag, elapsed}.
- One sub-module: tfe_prof_fifo (synchronous, show-ahead, DEPTH entries, full/empty flags, simultaneous push/pop).

## Test plan
- Start at i_time=100, tag=3; done at i_time=350 -> record {3, 250}, o_busy high for 250 cycles.
- Start at i_time=34'h3_FFFF_FFF0; done at i_time=34'h10 -> elapsed 32 (wrap).
- Start and done same cycle in IDLE, tag=5 -> record {5, 0}; done with start in RUN -> record pushed and new run starts at that timestamp.
- i_rec_ready held 0, 10 measurements with DEPTH=8 -> 8 records retained in order, o_drop_cnt=2; then drain -> 8 records, o_rec_valid drops.
- Second i_start during RUN -> o_overlap_err=1, first measurement's elapsed unchanged; rst mid-RUN -> no record, all outputs at reset values.
- With TFE_PROF_MAX_EN: elapsed 40, 90, 60 -> o_max_elapsed=90; without macro -> o_max_elapsed stays 0.
